fast_pulse_spacer: RTL and testbench
====================================

// Module: fast_pulse_spacer
// PURPOSE
//  Upstream feeder for the clka->clkb pulse stretcher/synchronizer. Accepts bursty
//  single-cycle event strobes in the fast clka domain and queues them in a saturating
//  pending counter. Re-emits them as isolated 1-cycle pulses, each followed by at least
//  MIN_GAP low cycles, so every pulse reaches the slow domain as a distinct edge.
// PARAMETERS
//  MIN_GAP  8  clka cycles pulse_out is held low after each pulse; legal range >= 1
//  CNT_W    4  pending counter width; capacity 2**CNT_W-1 queued events
// PORTS
//  clka      in   1      fast clock, rising edge
//  rst_n     in   1      asynchronous, active-low reset
//  ev_in     in   1      event strobe; one event per cycle it is high
//  clr_ovf   in   1      clears the sticky ovf flag
//  pulse_out out  1      spaced 1-cycle pulse, registered; drives the stretcher din
//  pending   out  CNT_W  queued events not yet emitted
//  busy      out  1      high when state!=IDLE or pending!=0
//  ovf       out  1      sticky; set when an event is dropped because the queue is full
// BEHAVIOUR
//  - Reset (async, rst_n low): state=IDLE, pulse_out=0, pending=0, ovf=0, gap_cnt=0.
//    Reset mid-operation discards all queued events; no pulse is emitted after release
//    unless ev_in occurs again.
//  - avail = (pending!=0) | ev_in. A take happens in the cycle the FSM moves to PULSE.
//  - FSM, registered state:
//    IDLE : avail -> PULSE (take); else stay.
//    PULSE: pulse_out=1 for exactly 1 cycle; -> GAP, gap_cnt <= MIN_GAP-1.
//    GAP  : pulse_out=0; gap_cnt decrements; at gap_cnt==0: avail -> PULSE (take), else IDLE.
//  - Latency: ev_in at cycle n with IDLE and pending=0 -> pulse_out high at n+1.
//  - Pulse period under backlog is exactly MIN_GAP+1 cycles.
//  - Pending update, evaluated in priority order:
//    ev_in & take     -> unchanged
//    ev_in & !take    -> +1, or drop and set ovf when pending==2**CNT_W-1
//    !ev_in & take    -> -1, applied only when pending>0
//  - A take with pending==0 consumes the same-cycle ev_in, so pending stays 0.
//  - Full queue with ev_in and take in the same cycle is not an overflow.
//  - ovf: set wins over clr_ovf in the same cycle; clr_ovf alone clears it next cycle.
//  - gap_cnt width is $clog2(MIN_GAP+1). pulse_out is a flop output with no comb path
//    from ev_in, as required by the CDC stage downstream.
// STRUCTURE
//  - State encodings (IDLE=2'd0, PULSE=2'd1, GAP=2'd2) go in the shared CDC constants
//    package/include, alongside the stretcher's constants.
//  - One sub-module: sat_updown_counter (CNT_W): inc, dec, count, full, drop outputs.
//  - FSM and gap counter stay in this module.
// TESTING (MIN_GAP=8, CNT_W=4 unless stated)
//  1 ev_in at cycle 10 only -> pulse_out high at 11 only; pending=0 throughout;
//    busy high 11..19, low from 20.
//  2 ev_in cycles 10..14 -> pulse_out at 11,20,29,38,47; pending=4 at cycle 15;
//    ovf stays 0.
//  3 ev_in cycles 10..29 -> events at 27 and 29 dropped; ovf=1 from cycle 28;
//    pending never >15; total 18 pulses, last at 164.
//  4 clr_ovf asserted in the same cycle as a dropped event -> ovf stays 1;
//    clr_ovf alone next cycle -> ovf=0 the cycle after.
//  5 rst_n low during GAP with pending=3 -> all outputs 0 immediately;
//    idle after release -> no pulse_out ever.
//  6 MIN_GAP=1, ev_in high for 6 cycles -> pulse_out pattern 1,0,1,0,1,0,...;
//    6 pulses total; busy drops after the last GAP cycle.

Source files
------------

// File: rtl/fast_pulse_spacer_pkg.sv
// Shared CDC constants for the clka-side pulse spacer feeding the clka->clkb stretcher.
// State encodings are fixed so the stretcher side can decode them if ever needed.
package fast_pulse_spacer_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StPulse = 2'd1,
    StGap   = 2'd2
  } spacer_state_e;

  // Minimum high time, in clkb cycles, the downstream stretcher guarantees per pulse.
  localparam int unsigned StretchMinHigh = 2;

  function automatic int unsigned gap_cnt_width(input int unsigned min_gap);
    return (min_gap < 2) ? 1 : $clog2(min_gap + 1);
  endfunction

endpackage

// File: rtl/sat_updown_counter.sv
// Saturating up/down event counter: inc and dec together cancel, inc at full is dropped,
// dec at zero is ignored.
module sat_updown_counter #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clka,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             drop
);

  logic [CNT_W-1:0] count_q, count_d;

  assign full  = (count_q == {CNT_W{1'b1}});
  assign count = count_q;

  always_comb begin
    count_d = count_q;
    drop    = 1'b0;
    if (inc && !dec) begin
      if (full) begin
        drop = 1'b1;
      end else begin
        count_d = count_q + CNT_W'(1);
      end
    end else if (dec && !inc && (count_q != '0)) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/fast_pulse_spacer.sv
// Queues bursty clka event strobes and re-emits them as 1-cycle pulses separated by at
// least MIN_GAP low cycles, so each one survives the slow-domain stretcher as an edge.
module fast_pulse_spacer
  import fast_pulse_spacer_pkg::*;
#(
  parameter int unsigned MIN_GAP = 8,
  parameter int unsigned CNT_W   = 4
) (
  input  logic             clka,
  input  logic             rst_n,
  input  logic             ev_in,
  input  logic             clr_ovf,
  output logic             pulse_out,
  output logic [CNT_W-1:0] pending,
  output logic             busy,
  output logic             ovf
);

  localparam int unsigned     GapW    = gap_cnt_width(MIN_GAP);
  localparam logic [GapW-1:0] GapLoad = GapW'(MIN_GAP - 1);

  spacer_state_e   state_q, state_d;
  logic [GapW-1:0] gap_q, gap_d;
  logic            pulse_q;
  logic            ovf_q, ovf_d;
  logic            avail, take;
  logic            full, drop;
  logic            unused_full;

  assign unused_full = full;

  // A same-cycle strobe counts as available, so an idle spacer answers in one cycle.
  assign avail = (pending != '0) | ev_in;

  sat_updown_counter #(
    .CNT_W (CNT_W)
  ) u_pending (
    .clka  (clka),
    .rst_n (rst_n),
    .inc   (ev_in),
    .dec   (take),
    .count (pending),
    .full  (full),
    .drop  (drop)
  );

  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    take    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (avail) begin
          state_d = StPulse;
          take    = 1'b1;
        end
      end
      StPulse: begin
        state_d = StGap;
        gap_d   = GapLoad;
      end
      StGap: begin
        if (gap_q == '0) begin
          if (avail) begin
            state_d = StPulse;
            take    = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end else begin
          gap_d = gap_q - GapW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Setting wins over clearing so a drop is never lost.
  always_comb begin
    ovf_d = ovf_q;
    if (drop) begin
      ovf_d = 1'b1;
    end else if (clr_ovf) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      gap_q   <= '0;
      pulse_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      pulse_q <= (state_d == StPulse);
      ovf_q   <= ovf_d;
    end
  end

  // Pulse comes straight from a flop: the CDC stage must not see ev_in glitches.
  assign pulse_out = pulse_q;
  assign ovf       = ovf_q;
  assign busy      = (state_q != StIdle) | (pending != '0);

endmodule

// File: tb/tb_fast_pulse_spacer.sv
// Bench for fast_pulse_spacer: timestamp/queue model checked every cycle on two
// instances (MIN_GAP=8 and MIN_GAP=1), plus literal expectations per directed scenario.
module tb_fast_pulse_spacer;

  localparam int NDut   = 2;
  localparam int CntMax = 15;
  localparam int NRec   = 256;

  logic       clka = 1'b0;
  logic       rst_n = 1'b0;
  logic       ev_in = 1'b0;
  logic       clr_ovf = 1'b0;
  logic       pulse0, busy0, ovf0;
  logic       pulse1, busy1, ovf1;
  logic [3:0] pend0, pend1;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int base = 0;

  int mg[NDut] = '{8, 1};
  int pend_m[NDut];
  int ovf_m[NDut];
  int last_m[NDut];

  int q0[$];
  int q1[$];
  int busy0_at[NRec];
  int busy1_at[NRec];
  int ovf0_at[NRec];
  int pend0_at[NRec];
  int max_pend0;

  always #5 clka = ~clka;
  always @(posedge clka) cyc <= cyc + 1;

  fast_pulse_spacer #(.MIN_GAP(8), .CNT_W(4)) u_dut0 (
    .clka      (clka),
    .rst_n     (rst_n),
    .ev_in     (ev_in),
    .clr_ovf   (clr_ovf),
    .pulse_out (pulse0),
    .pending   (pend0),
    .busy      (busy0),
    .ovf       (ovf0)
  );

  fast_pulse_spacer #(.MIN_GAP(1), .CNT_W(4)) u_dut1 (
    .clka      (clka),
    .rst_n     (rst_n),
    .ev_in     (ev_in),
    .clr_ovf   (clr_ovf),
    .pulse_out (pulse1),
    .pending   (pend1),
    .busy      (busy1),
    .ovf       (ovf1)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc - base);
    end
  endtask

  // Model: a take may happen at cycle c when something is available and
  // c >= last_pulse + MIN_GAP; the pulse then appears at c+1.
  always @(negedge clka) begin
    int act_p[NDut], act_b[NDut], act_o[NDut], act_q[NDut];
    int rel;
    act_p = '{int'(pulse0), int'(pulse1)};
    act_b = '{int'(busy0), int'(busy1)};
    act_o = '{int'(ovf0), int'(ovf1)};
    act_q = '{int'(pend0), int'(pend1)};
    if (!rst_n) begin
      for (int k = 0; k < NDut; k++) begin
        pend_m[k] = 0;
        ovf_m[k]  = 0;
        last_m[k] = -1000;
      end
    end
    for (int k = 0; k < NDut; k++) begin
      chk($sformatf("pulse%0d", k), act_p[k], int'(last_m[k] == cyc));
      chk($sformatf("pending%0d", k), act_q[k], pend_m[k]);
      chk($sformatf("busy%0d", k), act_b[k], int'(pend_m[k] != 0 || cyc <= last_m[k] + mg[k]));
      chk($sformatf("ovf%0d", k), act_o[k], ovf_m[k]);
    end
    rel = cyc - base;
    if (rst_n && rel >= 0 && rel < NRec) begin
      busy0_at[rel] = busy0;
      busy1_at[rel] = busy1;
      ovf0_at[rel]  = ovf0;
      pend0_at[rel] = pend0;
      if (pulse0) q0.push_back(rel);
      if (pulse1) q1.push_back(rel);
      if (pend0 > max_pend0) max_pend0 = pend0;
    end
    if (rst_n) begin
      for (int k = 0; k < NDut; k++) begin
        bit take, dropped;
        take    = (ev_in || pend_m[k] != 0) && (cyc >= last_m[k] + mg[k]);
        dropped = 1'b0;
        if (ev_in && take) begin
        end else if (ev_in) begin
          if (pend_m[k] == CntMax) dropped = 1'b1;
          else pend_m[k]++;
        end else if (take) begin
          pend_m[k]--;
        end
        if (dropped) ovf_m[k] = 1;
        else if (clr_ovf) ovf_m[k] = 0;
        if (take) last_m[k] = cyc + 1;
      end
    end
  end

  task automatic clear_records();
    q0.delete();
    q1.delete();
    max_pend0 = 0;
    for (int i = 0; i < NRec; i++) begin
      busy0_at[i] = -1;
      busy1_at[i] = -1;
      ovf0_at[i]  = -1;
      pend0_at[i] = -1;
    end
  endtask

  // Leaves the bench at #1 into relative cycle 0, just after reset release.
  task automatic do_reset();
    @(posedge clka);
    #1;
    rst_n   = 1'b0;
    ev_in   = 1'b0;
    clr_ovf = 1'b0;
    repeat (2) @(posedge clka);
    #1;
    rst_n = 1'b1;
    base  = cyc;
    clear_records();
  endtask

  task automatic run_ev(input int first, input int last, input int ncyc,
                        input int clr_a, input int clr_b);
    for (int r = 0; r < ncyc; r++) begin
      int rel;
      rel     = cyc - base;
      ev_in   = (rel >= first && rel <= last);
      clr_ovf = (rel == clr_a || rel == clr_b);
      @(posedge clka);
      #1;
    end
    ev_in   = 1'b0;
    clr_ovf = 1'b0;
  endtask

  initial begin
    int e2[5] = '{11, 20, 29, 38, 47};
    int e6[6] = '{11, 13, 15, 17, 19, 21};

    // 1: single event
    do_reset();
    run_ev(10, 10, 30, -1, -1);
    chk("t1_npulse", q0.size(), 1);
    if (q0.size() > 0) chk("t1_pulse_cycle", q0[0], 11);
    chk("t1_max_pending", max_pend0, 0);
    chk("t1_busy10", busy0_at[10], 0);
    chk("t1_busy11", busy0_at[11], 1);
    chk("t1_busy19", busy0_at[19], 1);
    chk("t1_busy20", busy0_at[20], 0);

    // 2: burst of five
    do_reset();
    run_ev(10, 14, 60, -1, -1);
    chk("t2_npulse", q0.size(), 5);
    for (int i = 0; i < 5; i++) if (i < q0.size()) chk("t2_pulse_cycle", q0[i], e2[i]);
    chk("t2_pending15", pend0_at[15], 4);
    chk("t2_ovf_end", int'(ovf0), 0);

    // 3: overflow burst
    do_reset();
    run_ev(10, 29, 180, -1, -1);
    chk("t3_ovf27", ovf0_at[27], 0);
    chk("t3_ovf28", ovf0_at[28], 1);
    chk("t3_max_pending", max_pend0, 15);
    chk("t3_npulse", q0.size(), 18);
    if (q0.size() > 0) chk("t3_last_pulse", q0[q0.size() - 1], 164);

    // 4: clear colliding with a drop, then a lone clear
    do_reset();
    run_ev(10, 27, 40, 27, 28);
    chk("t4_ovf28", ovf0_at[28], 1);
    chk("t4_ovf29", ovf0_at[29], 0);

    // 5: reset during GAP with pending=3
    do_reset();
    run_ev(10, 13, 15, -1, -1);
    chk("t5_pending_pre", int'(pend0), 3);
    rst_n = 1'b0;
    #1;
    chk("t5_pulse_rst", int'(pulse0), 0);
    chk("t5_pending_rst", int'(pend0), 0);
    chk("t5_busy_rst", int'(busy0), 0);
    chk("t5_ovf_rst", int'(ovf0), 0);
    repeat (2) @(posedge clka);
    #1;
    rst_n = 1'b1;
    base  = cyc;
    clear_records();
    run_ev(-1, -1, 60, -1, -1);
    chk("t5_npulse_after", q0.size(), 0);

    // 6: MIN_GAP=1 instance, six back-to-back events
    do_reset();
    run_ev(10, 15, 30, -1, -1);
    chk("t6_npulse", q1.size(), 6);
    for (int i = 0; i < 6; i++) if (i < q1.size()) chk("t6_pulse_cycle", q1[i], e6[i]);
    chk("t6_busy22", busy1_at[22], 1);
    chk("t6_busy23", busy1_at[23], 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
